// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// sdram_arb_pkg: shared state encoding, response-FIFO entry layout and sizing helper
// for the multi-port sdram_avl arbiter.  Rev 1.0
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_CMD   = 2'd1,
    ST_WR_BURST = 2'd2
  } arb_state_t;

  // Entry fields are sized for the widest supported configuration (8 channels,
  // 16-bit burst lengths); the FIFO itself stores only the bits in use.
  localparam int RSP_ID_MAX_W  = 3;
  localparam int RSP_LEN_MAX_W = 16;

  typedef struct packed {
    logic [RSP_ID_MAX_W-1:0]  id;
    logic [RSP_LEN_MAX_W-1:0] len;
  } rsp_entry_t;

  function automatic int ch_id_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_rsp_fifo.sv
`default_nettype none
// sdram_rsp_fifo: synchronous FIFO with registered full/empty flags; pop-while-full
// admits a push in the same cycle.  Rev 1.0
module sdram_rsp_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_LAST = (PTR_W + 1)'(DEPTH - 1);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + 1'b1;
          empty <= 1'b0;
          full  <= (count == CNT_LAST);
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == CNT_ONE);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_avl_mport_arbiter.sv
`default_nettype none
// sdram_avl_mport_arbiter: round-robin N-channel Avalon-MM burst front-end for the DDR3
// sdram_avl port, with in-order read-response routing.  Rev 1.0
module sdram_avl_mport_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 25,
  parameter int BURST_W   = 9,
  parameter int RSP_DEPTH = 16
) (
  input  logic                      sdram_afi_clk_clk,
  input  logic                      sdram_afi_reset_reset_n,
  input  logic [NUM_CH*ADDR_W-1:0]  ch_address,
  input  logic [NUM_CH*BURST_W-1:0] ch_burstcount,
  input  logic [NUM_CH*DATA_W-1:0]  ch_writedata,
  input  logic [NUM_CH-1:0]         ch_read,
  input  logic [NUM_CH-1:0]         ch_write,
  output logic [NUM_CH-1:0]         ch_waitrequest,
  output logic [NUM_CH-1:0]         ch_readdatavalid,
  output logic [DATA_W-1:0]         ch_readdata,
  output logic [ADDR_W-1:0]         sdram_avl_address,
  output logic [BURST_W-1:0]        sdram_avl_burstcount,
  output logic [DATA_W-1:0]         sdram_avl_writedata,
  output logic                      sdram_avl_read,
  output logic                      sdram_avl_write,
  output logic                      sdram_avl_beginbursttransfer,
  input  logic                      sdram_avl_waitrequest_n,
  input  logic                      sdram_avl_readdatavalid,
  input  logic [DATA_W-1:0]         sdram_avl_readdata,
  output logic                      err_rsp_underflow
);

  localparam int CH_ID_W = ch_id_w(NUM_CH);
  localparam int ENTRY_W = CH_ID_W + BURST_W;
  localparam logic [CH_ID_W:0]   NUM_CH_V = (CH_ID_W + 1)'(NUM_CH);
  localparam logic [CH_ID_W-1:0] LAST_CH  = CH_ID_W'(NUM_CH - 1);

  logic clk;
  logic rst_n;
  assign clk   = sdram_afi_clk_clk;
  assign rst_n = sdram_afi_reset_reset_n;

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [CH_ID_W-1:0] grant;
  logic [CH_ID_W-1:0] rr_ptr;
  logic [CH_ID_W-1:0] pick;
  logic [CH_ID_W:0]   slot;
  logic               pick_vld;
  logic               pick_wr;
  logic [BURST_W-1:0] pick_len;
  logic               first_cyc;
  logic [BURST_W-1:0] beat_cnt;
  logic [BURST_W-1:0] rsp_cnt;
  logic [NUM_CH-1:0]  eligible;
  logic [NUM_CH-1:0]  gnt_oh;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [BURST_W-1:0] gnt_bc;
  logic [DATA_W-1:0]  gnt_wdata;
  logic               gnt_rd;
  logic               gnt_wr;
  logic               rd_accept;
  logic               wr_accept;
  logic               cmd_done;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_head;
  rsp_entry_t         head;
  logic               rsp_last;

  function automatic logic [BURST_W-1:0] eff_len(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

  // A write never waits on the response FIFO, so it stays eligible when it is full.
  assign eligible = ch_write | (ch_read & {NUM_CH{~fifo_full}});

  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    slot     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      slot = {1'b0, rr_ptr} + (CH_ID_W + 1)'(k);
      if (slot >= NUM_CH_V) begin
        slot = slot - NUM_CH_V;
      end
      if (!pick_vld && eligible[slot[CH_ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = slot[CH_ID_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_addr  = '0;
    gnt_bc    = '0;
    gnt_wdata = '0;
    gnt_rd    = 1'b0;
    gnt_wr    = 1'b0;
    gnt_oh    = '0;
    pick_len  = '0;
    pick_wr   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_ID_W'(i)) begin
        gnt_addr  = ch_address[i*ADDR_W +: ADDR_W];
        gnt_bc    = ch_burstcount[i*BURST_W +: BURST_W];
        gnt_wdata = ch_writedata[i*DATA_W +: DATA_W];
        gnt_rd    = ch_read[i];
        gnt_wr    = ch_write[i];
        gnt_oh[i] = 1'b1;
      end
      if (pick == CH_ID_W'(i)) begin
        pick_len = eff_len(ch_burstcount[i*BURST_W +: BURST_W]);
        pick_wr  = ch_write[i];
      end
    end
  end

  assign sdram_avl_address    = gnt_addr;
  assign sdram_avl_burstcount = gnt_bc;
  assign sdram_avl_writedata  = gnt_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt                    = state;
    sdram_avl_read               = 1'b0;
    sdram_avl_write              = 1'b0;
    sdram_avl_beginbursttransfer = 1'b0;
    ch_waitrequest               = '1;
    rd_accept                    = 1'b0;
    wr_accept                    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = pick_wr ? ST_WR_BURST : ST_RD_CMD;
        end
      end
      ST_RD_CMD: begin
        sdram_avl_read               = gnt_rd;
        sdram_avl_beginbursttransfer = first_cyc;
        ch_waitrequest               = ~(gnt_oh & {NUM_CH{sdram_avl_waitrequest_n}});
        rd_accept                    = gnt_rd & sdram_avl_waitrequest_n;
        if (rd_accept) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        sdram_avl_write              = gnt_wr;
        sdram_avl_beginbursttransfer = first_cyc;
        ch_waitrequest               = ~(gnt_oh & {NUM_CH{sdram_avl_waitrequest_n}});
        wr_accept                    = gnt_wr & sdram_avl_waitrequest_n;
        if (wr_accept && beat_cnt == BURST_W'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cmd_done = rd_accept | (wr_accept & (beat_cnt == BURST_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      first_cyc <= 1'b0;
    end else begin
      first_cyc <= 1'b0;
      if (state == ST_IDLE && pick_vld) begin
        grant     <= pick;
        first_cyc <= 1'b1;
        beat_cnt  <= pick_len;
      end
      if (wr_accept) begin
        beat_cnt <= beat_cnt - 1'b1;
      end
      if (cmd_done) begin
        rr_ptr <= (grant == LAST_CH) ? '0 : grant + 1'b1;
      end
    end
  end

  assign fifo_push  = rd_accept;
  assign fifo_wdata = {grant, eff_len(gnt_bc)};

  sdram_rsp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head     = {RSP_ID_MAX_W'(fifo_head[BURST_W +: CH_ID_W]),
                     RSP_LEN_MAX_W'(fifo_head[BURST_W-1:0])};
  assign rsp_last = (RSP_LEN_MAX_W'(rsp_cnt) + RSP_LEN_MAX_W'(1)) == head.len;
  assign fifo_pop = sdram_avl_readdatavalid & ~fifo_empty & rsp_last;

  always_comb begin
    ch_readdatavalid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_readdatavalid[i] = sdram_avl_readdatavalid & ~fifo_empty
                            & (head.id == RSP_ID_MAX_W'(i));
    end
  end

  assign ch_readdata = sdram_avl_readdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_cnt           <= '0;
      err_rsp_underflow <= 1'b0;
    end else if (sdram_avl_readdatavalid) begin
      if (fifo_empty) begin
        err_rsp_underflow <= 1'b1;
      end else if (rsp_last) begin
        rsp_cnt <= '0;
      end else begin
        rsp_cnt <= rsp_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_avl_mport_arbiter.sv
`default_nettype none
// tb_sdram_avl_mport_arbiter: directed scoreboard bench with channel and controller models.
module tb_sdram_avl_mport_arbiter;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 25;
  localparam int BURST_W   = 9;
  localparam int RSP_DEPTH = 16;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_CH*ADDR_W-1:0]  ch_address;
  logic [NUM_CH*BURST_W-1:0] ch_burstcount;
  logic [NUM_CH*DATA_W-1:0]  ch_writedata;
  logic [NUM_CH-1:0]         ch_read;
  logic [NUM_CH-1:0]         ch_write;
  logic [NUM_CH-1:0]         ch_waitrequest;
  logic [NUM_CH-1:0]         ch_readdatavalid;
  logic [DATA_W-1:0]         ch_readdata;
  logic [ADDR_W-1:0]         sdram_avl_address;
  logic [BURST_W-1:0]        sdram_avl_burstcount;
  logic [DATA_W-1:0]         sdram_avl_writedata;
  logic                      sdram_avl_read;
  logic                      sdram_avl_write;
  logic                      sdram_avl_beginbursttransfer;
  logic                      sdram_avl_waitrequest_n;
  logic                      sdram_avl_readdatavalid;
  logic [DATA_W-1:0]         sdram_avl_readdata;
  logic                      err_rsp_underflow;

  always #5 clk = ~clk;

  sdram_avl_mport_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .sdram_afi_clk_clk            (clk),
    .sdram_afi_reset_reset_n      (rst_n),
    .ch_address                   (ch_address),
    .ch_burstcount                (ch_burstcount),
    .ch_writedata                 (ch_writedata),
    .ch_read                      (ch_read),
    .ch_write                     (ch_write),
    .ch_waitrequest               (ch_waitrequest),
    .ch_readdatavalid             (ch_readdatavalid),
    .ch_readdata                  (ch_readdata),
    .sdram_avl_address            (sdram_avl_address),
    .sdram_avl_burstcount         (sdram_avl_burstcount),
    .sdram_avl_writedata          (sdram_avl_writedata),
    .sdram_avl_read               (sdram_avl_read),
    .sdram_avl_write              (sdram_avl_write),
    .sdram_avl_beginbursttransfer (sdram_avl_beginbursttransfer),
    .sdram_avl_waitrequest_n      (sdram_avl_waitrequest_n),
    .sdram_avl_readdatavalid      (sdram_avl_readdatavalid),
    .sdram_avl_readdata           (sdram_avl_readdata),
    .err_rsp_underflow            (err_rsp_underflow)
  );

  // Channel-side model state
  int                 wr_left [NUM_CH];
  int                 wr_idx  [NUM_CH];
  int                 rd_left [NUM_CH];
  logic [ADDR_W-1:0]  addr_v  [NUM_CH];
  logic [BURST_W-1:0] bc_v    [NUM_CH];
  // Controller-side model state
  bit gap_en, ret_en, spurious;
  int wait_mode;
  int ctl_q[$];
  // Scoreboards: expected read-beat channel ids and expected write beats {ch, beat}
  int rd_exp[$];
  int wr_exp[$];

  int n_cmp, n_err, cyc, n_bbt, n_rd_cmd, n_wr_beats, tag;
  logic [ADDR_W-1:0]  last_rd_addr;
  logic [BURST_W-1:0] last_rd_bc;
  int base_bbt, base_rd, base_wr;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_address[i*ADDR_W +: ADDR_W]    = addr_v[i];
      ch_burstcount[i*BURST_W +: BURST_W] = bc_v[i];
      ch_writedata[i*DATA_W +: DATA_W]  = '0;
      ch_writedata[i*DATA_W +: 16]      = {8'(i), 8'(wr_idx[i])};
      ch_write[i] = (wr_left[i] > 0) && !(gap_en && wr_idx[i] > 0 && (cyc % 5 == 0));
      ch_read[i]  = (wr_left[i] == 0) && (rd_left[i] > 0);
    end
    sdram_avl_waitrequest_n = (wait_mode == 1) ? (cyc % 3 != 2) : 1'b1;
    sdram_avl_readdatavalid = spurious || (ret_en && ctl_q.size() > 0);
    sdram_avl_readdata      = '0;
    sdram_avl_readdata[31:0] = (ctl_q.size() > 0) ? 32'(ctl_q[0]) : 32'hdead;
  endtask

  // One clock: observe at the falling edge, then update inputs just after the rising edge.
  task automatic tick();
    int e, exp_w, eff;
    @(negedge clk);
    if (sdram_avl_beginbursttransfer) n_bbt++;
    if (sdram_avl_readdatavalid) begin
      if (rd_exp.size() > 0) begin
        e = rd_exp.pop_front();
        check("rdv_route", 64'(ch_readdatavalid), 64'(4'(1) << e));
        if (ctl_q.size() > 0) check("rdata_pass", 64'(ch_readdata[31:0]), 64'(ctl_q[0]));
      end else begin
        check("rdv_none", 64'(ch_readdatavalid), 64'(0));
      end
      if (ctl_q.size() > 0) void'(ctl_q.pop_front());
    end else begin
      check("rdv_quiet", 64'(ch_readdatavalid), 64'(0));
    end
    if (sdram_avl_read && sdram_avl_waitrequest_n) begin
      n_rd_cmd++;
      last_rd_addr = sdram_avl_address;
      last_rd_bc   = sdram_avl_burstcount;
      eff = (sdram_avl_burstcount == 0) ? 1 : int'(sdram_avl_burstcount);
      for (int k = 0; k < eff; k++) begin
        ctl_q.push_back(tag);
        tag++;
      end
    end
    if (sdram_avl_write && sdram_avl_waitrequest_n) begin
      n_wr_beats++;
      n_cmp++;
      assert (wr_exp.size() > 0) else begin
        n_err++;
        $error("FAIL wr_unexpected: observed beat %0h expected none", sdram_avl_writedata[15:0]);
      end
      if (wr_exp.size() > 0) begin
        exp_w = wr_exp.pop_front();
        check("wr_order", 64'(sdram_avl_writedata[15:0]), 64'(exp_w));
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_write[i] && !ch_waitrequest[i]) begin
        wr_left[i]--;
        wr_idx[i]++;
      end
      if (ch_read[i] && !ch_waitrequest[i]) rd_left[i]--;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  task automatic issue_write(input int ch, input int bc, input int addr);
    int n;
    n = (bc == 0) ? 1 : bc;
    wr_left[ch] = n;
    wr_idx[ch]  = 0;
    bc_v[ch]    = BURST_W'(bc);
    addr_v[ch]  = ADDR_W'(addr);
    for (int b = 0; b < n; b++) wr_exp.push_back((ch << 8) | b);
  endtask

  task automatic issue_read(input int ch, input int bc, input int cnt, input int addr);
    int n;
    n = (bc == 0) ? 1 : bc;
    rd_left[ch] = cnt;
    bc_v[ch]    = BURST_W'(bc);
    addr_v[ch]  = ADDR_W'(addr);
    for (int b = 0; b < n * cnt; b++) rd_exp.push_back(ch);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_left[i] = 0; wr_idx[i] = 0; rd_left[i] = 0; addr_v[i] = '0; bc_v[i] = '0;
    end
    ctl_q.delete(); rd_exp.delete(); wr_exp.delete();
    spurious = 1'b0;
    drive_inputs();
    for (int k = 0; k < n; k++) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; n_bbt = 0; n_rd_cmd = 0; n_wr_beats = 0; tag = 'h1000;
    gap_en = 1'b0; ret_en = 1'b1; spurious = 1'b0; wait_mode = 0;
    last_rd_addr = '0; last_rd_bc = '0;
    do_reset(3);

    // Reset state
    check("rst_read", 64'(sdram_avl_read), 64'(0));
    check("rst_write", 64'(sdram_avl_write), 64'(0));
    check("rst_bbt", 64'(sdram_avl_beginbursttransfer), 64'(0));
    check("rst_waitreq", 64'(ch_waitrequest), 64'(4'hf));
    check("rst_err", 64'(err_rsp_underflow), 64'(0));

    // Single ch0 read burst of 4 at 0x100
    base_bbt = n_bbt; base_rd = n_rd_cmd;
    issue_read(0, 4, 1, 'h100);
    drive_inputs();
    for (int t = 0; t < 60 && (rd_exp.size() > 0 || rd_left[0] > 0); t++) tick();
    check("t1_beats_left", 64'(rd_exp.size()), 64'(0));
    check("t1_rd_cmds", 64'(n_rd_cmd - base_rd), 64'(1));
    check("t1_bbt", 64'(n_bbt - base_bbt), 64'(1));
    check("t1_addr", 64'(last_rd_addr), 64'('h100));
    check("t1_bc", 64'(last_rd_bc), 64'(4));

    // Four simultaneous write bursts of 8 from a fresh round-robin pointer
    do_reset(2);
    base_bbt = n_bbt; base_wr = n_wr_beats;
    for (int c = 0; c < NUM_CH; c++) issue_write(c, 8, 'h200 + c * 'h40);
    drive_inputs();
    for (int t = 0; t < 200 && wr_exp.size() > 0; t++) tick();
    check("t2_pending", 64'(wr_exp.size()), 64'(0));
    check("t2_beats", 64'(n_wr_beats - base_wr), 64'(32));
    check("t2_bbt", 64'(n_bbt - base_bbt), 64'(4));

    // ch1 write burst 16 against a stalling controller and channel-side gaps
    base_bbt = n_bbt; base_wr = n_wr_beats;
    wait_mode = 1; gap_en = 1'b1;
    issue_write(1, 16, 'h400);
    drive_inputs();
    for (int t = 0; t < 200 && wr_left[1] > 0; t++) tick();
    for (int t = 0; t < 4; t++) tick();
    check("t3_beats", 64'(n_wr_beats - base_wr), 64'(16));
    check("t3_pending", 64'(wr_exp.size()), 64'(0));
    check("t3_bbt", 64'(n_bbt - base_bbt), 64'(1));
    wait_mode = 0; gap_en = 1'b0;

    // 17 single-beat reads with data withheld: the FIFO admits 16
    base_rd = n_rd_cmd;
    ret_en = 1'b0;
    issue_read(0, 1, 17, 'h800);
    drive_inputs();
    for (int t = 0; t < 120 && (n_rd_cmd - base_rd) < 16; t++) tick();
    for (int t = 0; t < 10; t++) tick();
    check("t4_accepted", 64'(n_rd_cmd - base_rd), 64'(16));
    check("t4_stalled", 64'(rd_left[0]), 64'(1));
    ret_en = 1'b1;
    drive_inputs();
    for (int t = 0; t < 120 && (rd_exp.size() > 0 || rd_left[0] > 0); t++) tick();
    check("t4_total", 64'(n_rd_cmd - base_rd), 64'(17));
    check("t4_drained", 64'(rd_exp.size()), 64'(0));

    // ch2 burst 2 then ch0 burst 3, returned in order; then burstcount 0 on ch3 as one beat
    issue_read(2, 2, 1, 'h900);
    drive_inputs();
    for (int t = 0; t < 40 && rd_left[2] > 0; t++) tick();
    issue_read(0, 3, 1, 'ha00);
    drive_inputs();
    for (int t = 0; t < 60 && (rd_exp.size() > 0 || rd_left[0] > 0); t++) tick();
    check("t5_drained", 64'(rd_exp.size()), 64'(0));
    base_rd = n_rd_cmd;
    issue_read(3, 0, 1, 'hb00);
    drive_inputs();
    for (int t = 0; t < 40 && (rd_exp.size() > 0 || rd_left[3] > 0); t++) tick();
    for (int t = 0; t < 3; t++) tick();
    check("t5_bc0_rd", 64'(n_rd_cmd - base_rd), 64'(1));
    check("t5_bc0_drained", 64'(rd_exp.size()), 64'(0));
    base_wr = n_wr_beats;
    issue_write(3, 0, 'hc00);
    drive_inputs();
    for (int t = 0; t < 40 && wr_left[3] > 0; t++) tick();
    for (int t = 0; t < 3; t++) tick();
    check("t5_bc0_wr", 64'(n_wr_beats - base_wr), 64'(1));

    // Reset mid write burst with a read outstanding, then a spurious beat
    ret_en = 1'b0;
    issue_read(0, 2, 1, 'hd00);
    drive_inputs();
    for (int t = 0; t < 40 && rd_left[0] > 0; t++) tick();
    issue_write(1, 16, 'he00);
    drive_inputs();
    for (int t = 0; t < 60 && wr_idx[1] < 5; t++) tick();
    check("t6_midburst", 64'(wr_left[1] > 0), 64'(1));
    ret_en = 1'b1;
    do_reset(2);
    check("t6_read", 64'(sdram_avl_read), 64'(0));
    check("t6_write", 64'(sdram_avl_write), 64'(0));
    check("t6_waitreq", 64'(ch_waitrequest), 64'(4'hf));
    check("t6_err_clear", 64'(err_rsp_underflow), 64'(0));
    spurious = 1'b1;
    drive_inputs();
    tick();
    spurious = 1'b0;
    drive_inputs();
    tick();
    check("t6_err_set", 64'(err_rsp_underflow), 64'(1));
    tick();
    check("t6_err_sticky", 64'(err_rsp_underflow), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
